// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with two-flop synchroniser and framing-error flag
//
// Receives asynchronous 8N1 frames on i_rx and presents each good byte on
// o_data with a one-cycle o_valid strobe. A low stop bit raises a one-cycle
// o_frameErr and leaves o_data untouched.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_reset_n   synchronous active-low reset
//   i_rx        asynchronous serial line, idles high
//   o_data      last correctly framed byte
//   o_valid     one-cycle pulse, o_data is new
//   o_frameErr  one-cycle pulse, stop bit sampled low
//   o_busy      high whenever the receiver is not idle

module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frameErr,
  output logic       o_busy
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state, state_nxt;
  logic          rx_m, rx_s;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [7:0]    data_nxt;
  logic          valid_nxt, ferr_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      o_data     <= 8'h00;
      o_valid    <= 1'b0;
      o_frameErr <= 1'b0;
    end else begin
      rx_m       <= i_rx;
      rx_s       <= rx_m;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      shift      <= shift_nxt;
      o_data     <= data_nxt;
      o_valid    <= valid_nxt;
      o_frameErr <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    data_nxt  = o_data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        // Re-check at mid start bit; a high line here was only a glitch.
        if (cnt == HALF) begin
          cnt_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          shift_nxt[idx] = rx_s;
          cnt_nxt        = '0;
          idx_nxt        = idx + 1'b1;
          if (idx == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        if (cnt == LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // A held-low (break) line must not look like a new start bit.
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed scoreboard bench for uart_rx at 16 clocks per bit

module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 3 + HALF + 9 * CPB;

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_rx       (rx),
    .o_data     (data),
    .o_valid    (valid),
    .o_frameErr (frame_err),
    .o_busy     (busy)
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
    bit         err;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] last_good = 8'h00;
  logic       prev_strobe = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (valid || frame_err) begin
      chk("strobe_exclusive", {30'd0, valid, frame_err} == 32'd3, 32'd0);
      chk("strobe_not_back_to_back", {31'd0, prev_strobe}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_kind_err", {31'd0, frame_err}, {31'd0, e.err});
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_data", {24'd0, data}, {24'd0, e.data});
      end
    end
    prev_strobe = valid || frame_err;
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_t e;
    e.cyc  = cyc + 1 + LAT;
    e.err  = !stop;
    e.data = stop ? d : last_good;
    if (stop) last_good = d;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle_jitter();
    rx = 1'b1;
    repeat ($urandom_range(1, 8)) @(negedge clk);
  endtask

  initial begin
    rx      = 1'b1;
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_data", {24'd0, data}, 32'h00);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    idle_jitter();

    // Single byte
    send_frame(8'h55, 1'b1);
    idle_jitter();

    // Back-to-back, no idle gap: strobe cycles are 160 apart by construction
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    idle_jitter();
    repeat (4) @(negedge clk);
    chk("b2b_drained", sb.size(), 32'd0);

    // Glitch: 4 low cycles must be rejected without a strobe
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    begin
      int n = 0;
      while (busy && n < HALF + 4) begin
        @(negedge clk);
        n++;
      end
    end
    chk("glitch_busy_clear", {31'd0, busy}, 32'd0);
    idle_jitter();
    send_frame(8'h3C, 1'b1);
    idle_jitter();

    // Framing error, then a long break
    send_frame(8'h81, 1'b0);
    repeat (100) @(negedge clk);
    chk("break_busy", {31'd0, busy}, 32'd1);
    chk("break_data_held", {24'd0, data}, 32'h3C);
    idle_jitter();
    repeat (4) @(negedge clk);
    chk("after_break_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h42, 1'b1);
    idle_jitter();

    // Reset during data bit 4 of a partial frame
    begin
      logic [7:0] part = 8'h5A;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(part[i]);
      rx = part[4];
      repeat (HALF) @(negedge clk);
      chk("pre_reset_busy", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      chk("midreset_data", {24'd0, data}, 32'h00);
      chk("midreset_valid", {31'd0, valid}, 32'd0);
      chk("midreset_ferr", {31'd0, frame_err}, 32'd0);
      chk("midreset_busy", {31'd0, busy}, 32'd0);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      reset_n   = 1'b1;
      last_good = 8'h00;
    end
    idle_jitter();
    send_frame(8'h99, 1'b1);
    idle_jitter();

    // Stream of D20 rolls as a transmitter would send them
    for (int r = 0; r < 100; r++) begin
      send_frame(8'($urandom_range(1, 20)), 1'b1);
      if ($urandom_range(0, 1) == 1) idle_jitter();
    end
    rx = 1'b1;
    repeat (CPB * 2) @(negedge clk);
    chk("final_drained", sb.size(), 32'd0);
    chk("final_last_data", {24'd0, data}, {24'd0, last_good});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the dice roller's host link, on the opposite end of the UART line that `postProcess` drives on `o_tx`. It accepts 8N1 asynchronous frames on `i_rx` and synchronises the line into the system clock domain. It presents each received byte on a parallel bus with a one-cycle valid strobe and flags frames whose stop bit is bad. Downstream logic uses the bytes to decode host commands, for example die selection. The block also closes the loop for loopback verification of `o_tx`.

## Interface
- `CLKS_PER_BIT`, default 868: system clocks per bit period (100 MHz / 115200). Legal range ≥ 4.
- `i_clk` in 1: system clock. All logic on the rising edge.
- `i_reset_n` in 1: reset, synchronous, active-low.
- `i_rx` in 1: asynchronous serial line. Idles high.
- `o_data` out 8: last correctly framed byte. Holds its value until the next good frame.
- `o_valid` out 1: one-cycle pulse; `o_data` is new in this cycle.
- `o_frameErr` out 1: one-cycle pulse; the stop bit sampled low.
- `o_busy` out 1: high in every state except IDLE.

## Operation
- Synchroniser:
  - 2-flop chain on `i_rx`, reset to 1.
  - The FSM sees only the second flop (`rx_s`).
- Counter `cnt`:
  - Width `$clog2(CLKS_PER_BIT)`. Constant `HALF = CLKS_PER_BIT/2` (integer division).
- States and transitions:
  - IDLE: `cnt=0`, bit index `0`. If `rx_s==0` → START.
  - START: if `cnt==HALF`, re-sample. `rx_s==0` → DATA with `cnt=0`. `rx_s==1` → IDLE (glitch rejected, no strobe). Otherwise `cnt++`.
  - DATA: if `cnt==CLKS_PER_BIT-1`, shift `rx_s` into bit[index], LSB first, then `cnt=0`, index++. After bit 7 → STOP. Otherwise `cnt++`.
  - STOP: if `cnt==CLKS_PER_BIT-1`, sample. `rx_s==1`: `o_data<=shift`, `o_valid<=1`, → IDLE. `rx_s==0`: `o_frameErr<=1`, `o_data` unchanged, → WAIT_HIGH. Otherwise `cnt++`.
  - WAIT_HIGH: stay until `rx_s==1`, then → IDLE. A held-low line (break) never starts a new frame.
- `o_valid` and `o_frameErr` are registered. They are never high together and never high two cycles in a row.
- Reset values: state IDLE, `o_data=8'h00`, `o_valid=0`, `o_frameErr=0`, `o_busy=0`, sync flops 1, `cnt=0`.
- Reset mid-frame: abandon immediately. No strobe. The partial byte is discarded and `o_data` returns to `8'h00`.

## Timing
- `i_rx` falls before edge k. `rx_s` is low after edge k+1, so START is entered at edge k+2.
- START → DATA at edge E = k+3+HALF.
- Data bit n is sampled at edge E+(n+1)·CLKS_PER_BIT. The stop bit is sampled at E+9·CLKS_PER_BIT.
- `o_valid` / `o_frameErr` are high for exactly the one cycle following edge k+3+HALF+9·CLKS_PER_BIT.
  - With `CLKS_PER_BIT=16` (HALF=8): edge k+155.
- Back-to-back frames: after a good stop, IDLE is reached mid-stop-bit. A start bit arriving right at the end of the stop bit is caught with no lost frame.
- Tolerance: the design samples at bit centre ±1 cycle. Sender rate error up to ±4 % must be received correctly.
- `o_busy` rises at edge k+2. It falls when IDLE is re-entered.

## Test plan
All scenarios use `CLKS_PER_BIT=16` and `$random` idle jitter.
- Single byte: send `0x55` → `o_data=0x55`, `o_valid` high one cycle at k+155, `o_frameErr` stays 0.
- Back-to-back: send `0xA3`, `0x0F`, `0xFF`, `0x00` with no idle gap → four `o_valid` pulses exactly 160 cycles apart, with the matching data.
- Glitch: drive `i_rx` low for 4 cycles, then high → no strobe, `o_busy` returns to 0 within HALF+4 cycles. A following `0x3C` is received correctly.
- Framing error: send `0x81` with stop bit 0, then hold low 100 cycles → `o_frameErr` one pulse, `o_data` keeps its previous value, no further strobe until the line goes high. A following `0x42` is received correctly.
- Reset mid-frame: assert `i_reset_n=0` during data bit 4 → next edge: all outputs at reset values. A following `0x99` is received correctly.
- Loopback: connect `postProcess.o_tx` to `i_rx` (matching baud) and perform 500 D20 rolls → each received byte equals the transmitted roll and is in the range 1..20.
